aes_key_schedule: RTL and testbench

AES-128 round-key generator and store. It is the responder to the main AES control FSM: it expands a 128-bit cipher key into round keys 0..10 at one round key per cycle. It then serves any round key by index on a registered read port, which the encrypt and decrypt round datapaths use. It replaces the per-round key-register enables with a single indexed bank, filled once per key change.

---
 rtl/aes_key_schedule.sv | 183 ++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: AES-128 round-key expander with an 11-entry round-key bank.
// A key_load expands key_in into round keys 0..10, one per cycle; any round key
// can then be read by index through a registered read port.
// Optional build macro: KEYSCHED_ZEROIZE_EN adds a zeroize input that wipes
// the bank and all expansion state in one cycle.

// Byte S-box: multiplicative inverse in GF(2^8) followed by the AES affine map.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] acc;
    p   = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      acc = gf_mul(acc, p);
    end
    return acc;
  endfunction

  // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Pure combinational substitution of one byte.
  // NOTE: combinational logic uses blocking assignments and assigns every output on every path, so no latch is inferred.
  always_comb begin
    dout = affine(gf_inv(din));
  end

endmodule

module aes_key_schedule (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
`ifdef KEYSCHED_ZEROIZE_EN
  input  logic         zeroize,
`endif
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         rd_err
);

  localparam int NUM_KEYS = 11;
  localparam logic [3:0] LAST_ROUND = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } state_t;

  state_t       state;
  logic [127:0] rk [NUM_KEYS];
  logic [7:0]   rcon;
  logic [3:0]   r;

  logic [127:0] prev_key;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  t_word;
  logic [31:0]  n0, n1, n2, n3;
  logic         wipe;

`ifdef KEYSCHED_ZEROIZE_EN
  assign wipe = zeroize;
`else
  assign wipe = 1'b0;
`endif

  // Round constant update: multiply by x in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Select the previous round key; r outside 1..11 never reaches the bank write.
  always_comb begin
    prev_key = '0;
    if (r != 4'd0 && r <= 4'd11) prev_key = rk[r - 4'd1];
  end

  assign rot_word = {prev_key[23:0], prev_key[31:24]};

  // SubWord: one shared S-box per byte lane.
  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (
      .din  (rot_word[8*b +: 8]),
      .dout (sub_word[8*b +: 8])
    );
  end

  // Next round key from the previous one, word by word.
  always_comb begin
    t_word = sub_word ^ {rcon, 24'h0};
    n0     = prev_key[127:96] ^ t_word;
    n1     = prev_key[95:64]  ^ n0;
    n2     = prev_key[63:32]  ^ n1;
    n3     = prev_key[31:0]   ^ n2;
  end

  // Control FSM and round-key bank writes.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      r          <= '0;
      rcon       <= '0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      // NOTE: the bank is reset explicitly because key material must not survive a reset; plain data memories normally are not.
      for (int i = 0; i < NUM_KEYS; i++) rk[i] <= '0;
    end else if (wipe) begin
      state      <= S_IDLE;
      r          <= '0;
      rcon       <= '0;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) rk[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (key_load) begin
            rk[0]      <= key_in;
            r          <= 4'd1;
            rcon       <= 8'h01;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
            state      <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          // key_load is deliberately ignored here; requesters wait for busy=0.
          rk[r] <= {n0, n1, n2, n3};
          rcon  <= xtime(rcon);
          r     <= r + 4'd1;
          if (r == LAST_ROUND) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered read port; reads see the bank as it was before this edge's write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_key <= '0;
      rd_err <= 1'b0;
    end else begin
      rd_err <= (rd_idx > LAST_ROUND);
      if (wipe || rd_idx > LAST_ROUND) rd_key <= '0;
      else                             rd_key <= rk[rd_idx];
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: FIPS-197 known answers plus random
// keys against a word-oriented FIPS-197 key expansion model with a table S-box.
// Build with KEYSCHED_ZEROIZE_EN defined to exercise the zeroize input.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0]   rd_idx = '0;
  logic         busy;
  logic         keys_valid;
  logic [127:0] rd_key;
  logic         rd_err;
`ifdef KEYSCHED_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [7:0] sbox_tab [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] exp_rk [11];

  always #5 clk = ~clk;

  aes_key_schedule dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_load   (key_load),
    .key_in     (key_in),
`ifdef KEYSCHED_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key),
    .rd_err     (rd_err)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // FIPS-197 KeyExpansion over the 44-word schedule, regrouped into 11 round keys.
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0)
        temp = model_sub_word({temp[23:0], temp[31:24]}) ^ {rcon_tab[i/4 - 1], 24'h0};
      w[i] = w[i-4] ^ temp;
    end
    for (int k = 0; k < 11; k++) exp_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] key);
    key_in   = key;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic read_key(input logic [3:0] idx, output logic [127:0] key, output logic err);
    rd_idx = idx;
    tick();
    key = rd_key;
    err = rd_err;
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    while (keys_valid !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [127:0] got;
    logic         err;
    reset_n = 1'b0;
    rd_idx  = 4'd15;
    tick();
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (keys_valid !== 1'b0) begin miscompares++; $display("FAIL reset_keys_valid: got %b expected 0", keys_valid); end
    vectors++; if (rd_key !== 128'h0) begin miscompares++; $display("FAIL reset_rd_key: got %h expected 0", rd_key); end
    vectors++; if (rd_err !== 1'b0) begin miscompares++; $display("FAIL reset_rd_err: got %b expected 0", rd_err); end
    reset_n = 1'b1;
    read_key(4'd7, got, err);
    vectors++; if (got !== 128'h0) begin miscompares++; $display("FAIL reset_bank_clear: got %h expected 0", got); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_idx7_err: got %b expected 0", err); end
  endtask

  task automatic test_fips_timing();
    logic [127:0] got;
    logic         err;
    load_key(FIPS_KEY);
    for (int c = 0; c < 10; c++) begin
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL expand_busy c%0d: got %b expected 1", c, busy); end
      vectors++; if (keys_valid !== 1'b0) begin miscompares++; $display("FAIL expand_valid c%0d: got %b expected 0", c, keys_valid); end
      tick();
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL done_busy: got %b expected 0", busy); end
    vectors++; if (keys_valid !== 1'b1) begin miscompares++; $display("FAIL done_valid: got %b expected 1", keys_valid); end
    read_key(4'd0, got, err);
    vectors++; if (got !== FIPS_KEY) begin miscompares++; $display("FAIL fips_rk0: got %h expected %h", got, FIPS_KEY); end
    read_key(4'd1, got, err);
    vectors++; if (got !== FIPS_RK1) begin miscompares++; $display("FAIL fips_rk1: got %h expected %h", got, FIPS_RK1); end
    read_key(4'd10, got, err);
    vectors++; if (got !== FIPS_RK10) begin miscompares++; $display("FAIL fips_rk10: got %h expected %h", got, FIPS_RK10); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL fips_rk10_err: got %b expected 0", err); end
  endtask

  task automatic test_read_all();
    logic [127:0] got;
    logic         err;
    logic [3:0]   idx_list [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                    4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15};
    model_expand(FIPS_KEY);
    for (int i = 0; i < 13; i++) begin
      read_key(idx_list[i], got, err);
      if (idx_list[i] <= 4'd10) begin
        vectors++; if (got !== exp_rk[idx_list[i]]) begin miscompares++; $display("FAIL read_all idx%0d: got %h expected %h", idx_list[i], got, exp_rk[idx_list[i]]); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL read_all_err idx%0d: got %b expected 0", idx_list[i], err); end
      end else begin
        vectors++; if (got !== 128'h0) begin miscompares++; $display("FAIL read_oob idx%0d: got %h expected 0", idx_list[i], got); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL read_oob_err idx%0d: got %b expected 1", idx_list[i], err); end
      end
    end
  endtask

  task automatic test_load_ignored();
    logic [127:0] key_a;
    logic [127:0] got;
    logic         err;
    int           cycles;
    key_a = rand_key();
    model_expand(key_a);
    load_key(key_a);
    tick(); tick(); tick();
    key_in   = ~key_a;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    wait_valid(30, cycles);
    vectors++; if (keys_valid !== 1'b1) begin miscompares++; $display("FAIL ignored_valid_timeout: got %b expected 1", keys_valid); end
    vectors++; if (cycles !== 6) begin miscompares++; $display("FAIL ignored_latency: got %0d expected 6", cycles); end
    for (int k = 0; k < 11; k++) begin
      read_key(4'(k), got, err);
      vectors++; if (got !== exp_rk[k]) begin miscompares++; $display("FAIL ignored_rk%0d: got %h expected %h", k, got, exp_rk[k]); end
    end
  endtask

  task automatic test_read_before_write();
    logic [127:0] old_rk3;
    logic [127:0] key_b;
    int           cycles;
    old_rk3 = exp_rk[3];
    key_b   = rand_key();
    model_expand(key_b);
    load_key(key_b);
    tick();
    tick();
    rd_idx = 4'd3;
    tick();
    vectors++; if (rd_key !== old_rk3) begin miscompares++; $display("FAIL rbw_old: got %h expected %h", rd_key, old_rk3); end
    tick();
    vectors++; if (rd_key !== exp_rk[3]) begin miscompares++; $display("FAIL rbw_new: got %h expected %h", rd_key, exp_rk[3]); end
    wait_valid(30, cycles);
    vectors++; if (keys_valid !== 1'b1) begin miscompares++; $display("FAIL rbw_valid_timeout: got %b expected 1", keys_valid); end
  endtask

  task automatic test_reload_zero();
    logic [127:0] got;
    logic         err;
    int           cycles;
    load_key(128'h0);
    vectors++; if (keys_valid !== 1'b0) begin miscompares++; $display("FAIL reload_valid_drop: got %b expected 0", keys_valid); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL reload_busy: got %b expected 1", busy); end
    wait_valid(30, cycles);
    vectors++; if (cycles !== 10) begin miscompares++; $display("FAIL reload_latency: got %0d expected 10", cycles); end
    read_key(4'd10, got, err);
    vectors++; if (got !== ZERO_RK10) begin miscompares++; $display("FAIL zero_rk10: got %h expected %h", got, ZERO_RK10); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] key_c;
    logic [127:0] got;
    logic         err;
    int           cycles;
    key_c = rand_key();
    model_expand(key_c);
    load_key(key_c);
    repeat (5) tick();
    rd_idx  = 4'd0;
    reset_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    vectors++; if (keys_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b expected 0", keys_valid); end
    vectors++; if (rd_key !== 128'h0) begin miscompares++; $display("FAIL midrst_rd_key: got %h expected 0", rd_key); end
    tick();
    vectors++; if (rd_key !== 128'h0) begin miscompares++; $display("FAIL midrst_rd_key_held: got %h expected 0", rd_key); end
    reset_n = 1'b1;
    read_key(4'd0, got, err);
    vectors++; if (got !== 128'h0) begin miscompares++; $display("FAIL midrst_rk0_cleared: got %h expected 0", got); end
    read_key(4'd4, got, err);
    vectors++; if (got !== 128'h0) begin miscompares++; $display("FAIL midrst_rk4_cleared: got %h expected 0", got); end
    load_key(key_c);
    wait_valid(30, cycles);
    vectors++; if (keys_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_reload_timeout: got %b expected 1", keys_valid); end
    for (int k = 0; k < 11; k++) begin
      read_key(4'(k), got, err);
      vectors++; if (got !== exp_rk[k]) begin miscompares++; $display("FAIL midrst_rk%0d: got %h expected %h", k, got, exp_rk[k]); end
    end
  endtask

  task automatic test_random_keys();
    logic [127:0] key_r;
    logic [127:0] got;
    logic         err;
    int           cycles;
    for (int n = 0; n < 4; n++) begin
      key_r = rand_key();
      model_expand(key_r);
      load_key(key_r);
      wait_valid(30, cycles);
      vectors++; if (keys_valid !== 1'b1) begin miscompares++; $display("FAIL rand%0d_timeout: got %b expected 1", n, keys_valid); end
      for (int k = 10; k >= 0; k--) begin
        read_key(4'(k), got, err);
        vectors++; if (got !== exp_rk[k]) begin miscompares++; $display("FAIL rand%0d_rk%0d: got %h expected %h", n, k, got, exp_rk[k]); end
      end
    end
  endtask

`ifdef KEYSCHED_ZEROIZE_EN
  task automatic test_zeroize();
    logic [127:0] got;
    logic         err;
    zeroize  = 1'b1;
    key_load = 1'b1;
    key_in   = rand_key();
    rd_idx   = 4'd0;
    tick();
    zeroize  = 1'b0;
    key_load = 1'b0;
    vectors++; if (keys_valid !== 1'b0) begin miscompares++; $display("FAIL zeroize_valid: got %b expected 0", keys_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zeroize_busy: got %b expected 0", busy); end
    vectors++; if (rd_key !== 128'h0) begin miscompares++; $display("FAIL zeroize_rd_key: got %h expected 0", rd_key); end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zeroize_no_expand c%0d: got %b expected 0", c, busy); end
    end
    for (int k = 0; k < 11; k++) begin
      read_key(4'(k), got, err);
      vectors++; if (got !== 128'h0) begin miscompares++; $display("FAIL zeroize_rk%0d: got %h expected 0", k, got); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fips_timing();
    test_read_all();
    test_load_ignored();
    test_read_before_write();
    test_reload_zero();
    test_reset_mid();
    test_random_keys();
`ifdef KEYSCHED_ZEROIZE_EN
    test_zeroize();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
